// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage.
//   - instruction mode and opcode constants
//   - EX command encodings (exe_cmd_e)
//   - condition codes and the 9-bit control bundle (ctrl_t)
//   - control_unit(): mode/opcode/S -> control bundle
//   - cond_check(): condition field vs NZCV
package id_pkg;

    localparam int unsigned CTRL_W = 9;

    localparam logic [1:0] MODE_ARITH  = 2'b00;
    localparam logic [1:0] MODE_MEM    = 2'b01;
    localparam logic [1:0] MODE_BRANCH = 2'b10;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] COND_AL = 4'hE;

    typedef enum logic [3:0] {
        EXE_NOP = 4'b0000,
        EXE_MOV = 4'b0001,
        EXE_ADD = 4'b0010,
        EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100,
        EXE_SBC = 4'b0101,
        EXE_AND = 4'b0110,
        EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000,
        EXE_MVN = 4'b1001
    } exe_cmd_e;

    typedef struct packed {
        logic     s_upd;
        logic     branch;
        exe_cmd_e exe_cmd;
        logic     mem_w;
        logic     mem_r;
        logic     wb_en;
    } ctrl_t;

    function automatic ctrl_t control_unit(input logic [1:0] mode, input logic [3:0] opcode,
                                           input logic s);
        ctrl_t c;
        c = '0;
        case (mode)
            MODE_ARITH: begin
                c.s_upd = s;
                c.wb_en = 1'b1;
                case (opcode)
                    OP_MOV: c.exe_cmd = EXE_MOV;
                    OP_MVN: c.exe_cmd = EXE_MVN;
                    OP_ADD: c.exe_cmd = EXE_ADD;
                    OP_ADC: c.exe_cmd = EXE_ADC;
                    OP_SUB: c.exe_cmd = EXE_SUB;
                    OP_SBC: c.exe_cmd = EXE_SBC;
                    OP_AND: c.exe_cmd = EXE_AND;
                    OP_ORR: c.exe_cmd = EXE_ORR;
                    OP_EOR: c.exe_cmd = EXE_EOR;
                    // Compare/test only produce flags.
                    OP_CMP: begin
                        c.exe_cmd = EXE_SUB;
                        c.wb_en   = 1'b0;
                    end
                    OP_TST: begin
                        c.exe_cmd = EXE_AND;
                        c.wb_en   = 1'b0;
                    end
                    default: begin
                        c.wb_en = 1'b0;
                        c.s_upd = 1'b0;
                    end
                endcase
            end
            // S bit selects load (1) or store (0); address is Rn + offset.
            MODE_MEM: begin
                c.exe_cmd = EXE_ADD;
                if (s) begin
                    c.mem_r = 1'b1;
                    c.wb_en = 1'b1;
                end else begin
                    c.mem_w = 1'b1;
                end
            end
            MODE_BRANCH: c.branch = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // nzcv = {N, Z, C, V}
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, ok;
        {n, z, c, v} = nzcv;
        case (cond)
            4'h0:    ok = z;
            4'h1:    ok = !z;
            4'h2:    ok = c;
            4'h3:    ok = !c;
            4'h4:    ok = n;
            4'h5:    ok = !n;
            4'h6:    ok = v;
            4'h7:    ok = !v;
            4'h8:    ok = c && !z;
            4'h9:    ok = !c || z;
            4'hA:    ok = (n == v);
            4'hB:    ok = (n != v);
            4'hC:    ok = !z && (n == v);
            4'hD:    ok = z || (n != v);
            4'hE:    ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Per-register writes-in-flight counters plus one counter for the status flags.
//   clk, rst             clock, synchronous active-high reset
//   inc_en/inc_idx       issued instruction will write register inc_idx
//   dec_en/dec_idx       writeback retires a write to dec_idx
//   flag_inc/flag_dec    flag-setting instruction issued / retired
//   src1_idx, src2_idx   source registers of the instruction in decode
//   rd_idx               destination of the instruction in decode
//   src1_busy/src2_busy  source still has an outstanding write
//   rd_sat               destination counter cannot take another write
//   flag_busy/flag_sat   flag counter non-zero / full
module id_scoreboard #(
    parameter int unsigned NREGS   = 16,
    parameter int unsigned CNT_W   = 2,
    parameter bit          DEC_FWD = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inc_en,
    input  logic [$clog2(NREGS)-1:0] inc_idx,
    input  logic                     dec_en,
    input  logic [$clog2(NREGS)-1:0] dec_idx,
    input  logic                     flag_inc,
    input  logic                     flag_dec,
    input  logic [$clog2(NREGS)-1:0] src1_idx,
    input  logic [$clog2(NREGS)-1:0] src2_idx,
    input  logic [$clog2(NREGS)-1:0] rd_idx,
    output logic                     src1_busy,
    output logic                     src2_busy,
    output logic                     rd_sat,
    output logic                     flag_busy,
    output logic                     flag_sat
);
    localparam int unsigned RA_W = $clog2(NREGS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];
    logic [CNT_W-1:0] flag_q, flag_d;

    function automatic logic [CNT_W-1:0] step(input logic [CNT_W-1:0] c, input logic inc,
                                              input logic dec);
        logic [CNT_W-1:0] n;
        n = c;
        if (inc && !dec) n = c + CNT_W'(1);
        // A retire with nothing in flight is a downstream error; hold at zero.
        else if (dec && !inc && c != '0) n = c - CNT_W'(1);
        return n;
    endfunction

    // Count as seen by decode once this cycle's writeback is credited.
    function automatic logic [CNT_W-1:0] eff(input logic [CNT_W-1:0] c, input logic dec);
        return (dec && c != '0) ? c - CNT_W'(1) : c;
    endfunction

    // Source readiness may only credit the writeback when its value is forwarded
    // into the register-file read in the same cycle.
    logic dec_src1, dec_src2, dec_rd;
    assign dec_src1 = DEC_FWD && dec_en && (dec_idx == src1_idx);
    assign dec_src2 = DEC_FWD && dec_en && (dec_idx == src2_idx);
    assign dec_rd   = dec_en && (dec_idx == rd_idx);

    assign src1_busy = eff(cnt_q[src1_idx], dec_src1) != '0;
    assign src2_busy = eff(cnt_q[src2_idx], dec_src2) != '0;
    assign rd_sat    = eff(cnt_q[rd_idx], dec_rd) == CNT_MAX;
    assign flag_busy = eff(flag_q, flag_dec) != '0;
    assign flag_sat  = eff(flag_q, flag_dec) == CNT_MAX;

    always_comb begin
        for (int unsigned r = 0; r < NREGS; r++) begin
            cnt_d[r] = step(cnt_q[r], inc_en && (inc_idx == RA_W'(r)),
                            dec_en && (dec_idx == RA_W'(r)));
        end
        flag_d = step(flag_q, flag_inc, flag_dec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREGS; r++) cnt_q[r] <= '0;
            flag_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

endmodule

// File: rtl/id_stage_sb.sv
// Decode stage with register file, scoreboard-based hazard detection and an
// ID/EX output register behind a valid/ready handshake.
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         IF/ID handshake; in_ready = instruction issued or flushed
//   pc_in, instr_in           instruction from IF/ID
//   flush                     kill the instruction currently in decode
//   status_reg                NZCV flags
//   wb_en/wb_dest/wb_value    register-file writeback
//   sr_upd                    a flag-setting instruction retired this cycle
//   out_valid/out_ready       ID/EX handshake
//   out_ctrl ... out_shift    registered bundle to EX
//   stall_o                   scoreboard stall indication
module id_stage_sb
    import id_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NREGS     = 16,
    parameter int unsigned CNT_W     = 2,
    parameter int unsigned WB_BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              pc_in,
    input  logic [31:0]              instr_in,
    input  logic                     flush,
    input  logic [3:0]               status_reg,
    input  logic                     wb_en,
    input  logic [$clog2(NREGS)-1:0] wb_dest,
    input  logic [DATA_W-1:0]        wb_value,
    input  logic                     sr_upd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [DATA_W-1:0]        out_rn_val,
    output logic [DATA_W-1:0]        out_rm_val,
    output logic [31:0]              out_pc,
    output logic [23:0]              out_imm24,
    output logic [$clog2(NREGS)-1:0] out_rd,
    output logic                     out_imm,
    output logic [11:0]              out_shift,
    output logic                     stall_o
);
    localparam int unsigned RA_W = $clog2(NREGS);

    // Field extraction
    logic [3:0]      cond, opcode;
    logic [1:0]      mode;
    logic            i_bit, s_bit;
    logic [RA_W-1:0] rn_idx, rd_idx, rm_idx, src2_idx;

    assign cond   = instr_in[31:28];
    assign mode   = instr_in[27:26];
    assign i_bit  = instr_in[25];
    assign opcode = instr_in[24:21];
    assign s_bit  = instr_in[20];
    assign rn_idx = RA_W'(instr_in[19:16]);
    assign rd_idx = RA_W'(instr_in[15:12]);
    assign rm_idx = RA_W'(instr_in[3:0]);

    ctrl_t ctrl, issued_ctrl;
    logic  cond_ok;

    assign ctrl     = control_unit(mode, opcode, s_bit);
    assign cond_ok  = cond_check(cond, status_reg);
    // Stores read the data register through the second port.
    assign src2_idx = ctrl.mem_w ? rd_idx : rm_idx;

    // Register file with optional same-cycle writeback forwarding
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] rn_val, src2_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else if (wb_en) begin
            regs_q[wb_dest] <= wb_value;
        end
    end

    always_comb begin
        rn_val   = regs_q[rn_idx];
        src2_val = regs_q[src2_idx];
        if (WB_BYPASS != 0 && wb_en && wb_dest == rn_idx)   rn_val   = wb_value;
        if (WB_BYPASS != 0 && wb_en && wb_dest == src2_idx) src2_val = wb_value;
    end

    // Hazard detection
    logic rn_used, src2_used;
    logic src1_busy, src2_busy, rd_sat, flag_busy, flag_sat;
    logic load_en, issue;

    assign rn_used   = !ctrl.branch && (opcode != OP_MOV) && (opcode != OP_MVN);
    assign src2_used = !i_bit || ctrl.mem_w;

    assign stall_o = in_valid && !flush &&
                     ((rn_used && src1_busy) || (src2_used && src2_busy) ||
                      ((cond != COND_AL) && flag_busy) ||
                      (ctrl.wb_en && rd_sat) || (ctrl.s_upd && flag_sat));

    assign load_en  = !out_valid || out_ready;
    assign issue    = in_valid && !flush && !stall_o && load_en;
    assign in_ready = flush || issue;

    // A failed condition still issues, as a bubble that claims no resources.
    assign issued_ctrl = cond_ok ? ctrl : '0;

    id_scoreboard #(
        .NREGS   (NREGS),
        .CNT_W   (CNT_W),
        .DEC_FWD (WB_BYPASS != 0)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .inc_en    (issue && issued_ctrl.wb_en),
        .inc_idx   (rd_idx),
        .dec_en    (wb_en),
        .dec_idx   (wb_dest),
        .flag_inc  (issue && issued_ctrl.s_upd),
        .flag_dec  (sr_upd),
        .src1_idx  (rn_idx),
        .src2_idx  (src2_idx),
        .rd_idx    (rd_idx),
        .src1_busy (src1_busy),
        .src2_busy (src2_busy),
        .rd_sat    (rd_sat),
        .flag_busy (flag_busy),
        .flag_sat  (flag_sat)
    );

    // ID/EX output register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_ctrl   <= '0;
            out_rn_val <= '0;
            out_rm_val <= '0;
            out_pc     <= '0;
            out_imm24  <= '0;
            out_rd     <= '0;
            out_imm    <= 1'b0;
            out_shift  <= '0;
        end else if (load_en) begin
            if (!issue) begin
                out_valid <= 1'b0;
                out_ctrl  <= '0;
            end else begin
                out_valid  <= 1'b1;
                out_ctrl   <= issued_ctrl;
                out_rn_val <= rn_val;
                out_rm_val <= src2_val;
                out_pc     <= pc_in;
                out_imm24  <= instr_in[23:0];
                out_rd     <= rd_idx;
                out_imm    <= i_bit;
                out_shift  <= instr_in[11:0];
            end
        end
    end

endmodule
